// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command master: protocol opcodes, frame size, FSM states.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
`timescale 1ns/1ps
package spi_cmd_pkg;

    // Command opcodes understood by the SB_SPI-based slave
    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_INIT        = 8'h01;
    localparam logic [7:0] OP_WR_INVERTED = 8'h02;
    localparam logic [7:0] OP_WR_LEDS     = 8'h04;
    localparam logic [7:0] OP_WR_VEC      = 8'h06;
    localparam logic [7:0] OP_RD_VEC      = 8'h07;

    // Single byte the slave expects as its initialisation handshake
    localparam logic [7:0] INIT_BYTE      = 8'h11;

    localparam int FRAME_BYTES = 8;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_bit_timer.sv
// SCK half-period prescaler: pulses tick on the last CLK of every CLK_DIV-cycle half period.
// Latency: first tick CLK_DIV cycles after en rises; counter restarts from zero whenever en is low.
// Backpressure: none, free-running while enabled.
`timescale 1ns/1ps
module spi_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q;

    assign tick = en && (div_q == DIV_LAST);

    // Count CLK cycles within a half period; cleared outside the shift phase so every byte starts aligned
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q <= '0;
        end else if (!en || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// Mode-0 LSB-first SPI master sending 8-byte command frames and capturing the 8 reply bytes.
// Latency: 2*CS_SETUP + 128*CLK_DIV + 7*BYTE_GAP + 1 CLK from accept to the rsp_valid pulse.
// Backpressure: cmd_ready only in IDLE; one frame in flight; cmd_* ignored while busy.
// Optional: SPI_CMD_MASTER_AUTO_INIT_EN sends a 1-byte 0x11 INIT frame after reset, with no rsp_valid.
`timescale 1ns/1ps
module spi_cmd_master #(
    parameter int CLK_DIV  = 4,
    parameter int BYTE_GAP = 64,
    parameter int CS_SETUP = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [55:0] cmd_payload,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    import spi_cmd_pkg::*;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(BYTE_GAP - 1);
    localparam logic [2:0] LAST_BYTE  = 3'(FRAME_BYTES - 1);
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
    localparam logic       RDY_RST    = 1'b0;
`else
    localparam logic       RDY_RST    = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ph_q, ph_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic [2:0]  last_byte;
    logic [63:0] tx_q, tx_d;
    logic [63:0] rx_q, rx_d;
    logic        miso_s1, miso_s2;
    logic        tick;
    logic        shift_en;
    logic        ss_d, sck_d, mosi_d, busy_d, rdy_d, vld_d;
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
    logic        init_pend_q, init_pend_d;
    logic        auto_q, auto_d;
`endif

    assign shift_en = (state_q == ST_SHIFT);

    spi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (shift_en),
        .tick  (tick)
    );

    // Two-flop synchroniser for the slave's data line
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= SPI_MISO;
            miso_s2 <= miso_s1;
        end
    end

    // Next-state, counters and shift registers; ph_q is the SCK phase (0 = low half, 1 = high half)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        last_byte = LAST_BYTE;
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
        init_pend_d = init_pend_q;
        auto_d      = auto_q;
        if (auto_q) last_byte = 3'd0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                ph_d   = 1'b0;
                bit_d  = '0;
                byte_d = '0;
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
                if (init_pend_q) begin
                    tx_d        = {56'h0, INIT_BYTE};
                    auto_d      = 1'b1;
                    init_pend_d = 1'b0;
                    state_d     = ST_SETUP;
                end else
`endif
                if (cmd_valid && cmd_ready) begin
                    tx_d    = {cmd_payload, cmd_opcode};
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
                    auto_d  = 1'b0;
`endif
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    ph_d = ~ph_q;
                    // End of the high half: capture MISO and advance to the next bit
                    if (ph_q) begin
                        rx_d  = {miso_s2, rx_q[63:1]};
                        tx_d  = {1'b0, tx_q[63:1]};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_d  = byte_q + 3'd1;
                            state_d = (byte_q == last_byte) ? ST_HOLD : ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
                    // The INIT frame is internal: no response is reported
                    state_d = auto_q ? ST_IDLE : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so pins change glitch-free, aligned with the state
    assign ss_d   = !(state_d inside {ST_SETUP, ST_SHIFT, ST_GAP, ST_HOLD});
    assign sck_d  = (state_d == ST_SHIFT) && ph_d;
    assign mosi_d = (state_d == ST_SHIFT) && tx_d[0];
    assign busy_d = (state_d != ST_IDLE);
    assign vld_d  = (state_d == ST_DONE);
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
    assign rdy_d  = (state_d == ST_IDLE) && !init_pend_d;
`else
    assign rdy_d  = (state_d == ST_IDLE);
`endif

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ph_q      <= 1'b0;
            bit_q     <= '0;
            byte_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            cmd_ready <= RDY_RST;
            SPI_SS    <= 1'b1;
            SPI_SCK   <= 1'b0;
            SPI_MOSI  <= 1'b0;
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
            init_pend_q <= 1'b1;
            auto_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rsp_valid <= vld_d;
            busy      <= busy_d;
            cmd_ready <= rdy_d;
            SPI_SS    <= ss_d;
            SPI_SCK   <= sck_d;
            SPI_MOSI  <= mosi_d;
            if (state_d == ST_DONE) begin
                rsp_data <= rx_q;
            end
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
            init_pend_q <= init_pend_d;
            auto_q      <= auto_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: mode-0 LSB-first slave model, frame latency and response checks.
// Latency: expected frame latency computed from the timing parameters.
// Backpressure: holds cmd_valid across frames to exercise back-to-back accepts.
`timescale 1ns/1ps
module tb_spi_cmd_master;

    localparam int DIV = 4;
    localparam int GAP = 64;
    localparam int CSU = 4;
    localparam int LAT = CSU + 64 * 2 * DIV + 7 * GAP + CSU + 1;
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
    localparam logic RDY_RST = 1'b0;
`else
    localparam logic RDY_RST = 1'b1;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [55:0] cmd_payload = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        busy;
    logic        SPI_SCK, SPI_SS, SPI_MOSI;
    logic        SPI_MISO = 1'b0;

    spi_cmd_master #(
        .CLK_DIV  (DIV),
        .BYTE_GAP (GAP),
        .CS_SETUP (CSU)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_payload (cmd_payload),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .SPI_SCK     (SPI_SCK),
        .SPI_SS      (SPI_SS),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Behavioural mode-0 slave: samples MOSI on SCK rise, presents next reply bit on SCK fall, LSB first
    logic [63:0] slv_tx = '0;
    logic [63:0] slv_rx = '0;
    int          slv_bits = 0;
    int          sck_rises = 0;
    int          ss_falls = 0;
    int          ss_rises = 0;
    logic        ss_prev = 1'b1;
    logic        sck_prev = 1'b0;

    always @(SPI_SS or SPI_SCK) begin
        if (ss_prev === 1'b1 && SPI_SS === 1'b0) begin
            ss_falls++;
            slv_bits = 0;
            slv_rx   = '0;
            SPI_MISO = slv_tx[0];
        end
        if (ss_prev === 1'b0 && SPI_SS === 1'b1) ss_rises++;
        if (sck_prev === 1'b0 && SPI_SCK === 1'b1) begin
            sck_rises++;
            if (SPI_SS === 1'b0 && slv_bits < 64) slv_rx[slv_bits[5:0]] = SPI_MOSI;
            slv_bits++;
        end
        if (sck_prev === 1'b1 && SPI_SCK === 1'b0 && SPI_SS === 1'b0 && slv_bits < 64)
            SPI_MISO = slv_tx[slv_bits[5:0]];
        ss_prev  = SPI_SS;
        sck_prev = SPI_SCK;
    end

    // Response pulse monitor
    int   rsp_pulses = 0;
    int   rsp_hi = 0;
    logic rsp_prev = 1'b0;
    always @(negedge CLK) begin
        if (rsp_valid === 1'b1) begin
            rsp_hi++;
            if (!rsp_prev) rsp_pulses++;
        end
        rsp_prev = (rsp_valid === 1'b1);
    end

    // One complete frame; returns at the negedge of the rsp_valid cycle
    task automatic run_frame(input string tag, input logic [7:0] op, input logic [55:0] pl,
                             input logic [63:0] resp, input bit keep, output int acc, output int done);
        int n;
        int r0, f0, u0;
        bit rdy_err;
        slv_tx      = resp;
        cmd_opcode  = op;
        cmd_payload = pl;
        cmd_valid   = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_accept"}, 64'(n < 2000), 64'd1);
        acc = cyc;
        r0  = sck_rises;
        f0  = ss_falls;
        u0  = ss_rises;
        @(negedge CLK);
        if (!keep) cmd_valid = 1'b0;
        cmd_opcode  = 8'($urandom());
        cmd_payload = 56'(rnd64());
        chk({tag, "_ss_setup"}, 64'(SPI_SS), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        rdy_err = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < LAT + 100) begin
            if (cmd_ready !== 1'b0) rdy_err = 1'b1;
            @(negedge CLK);
            n++;
        end
        done = cyc;
        chk({tag, "_latency"}, 64'(done - acc), 64'(LAT));
        chk({tag, "_rdy_low"}, 64'(rdy_err), 64'd0);
        chk({tag, "_sck_rises"}, 64'(sck_rises - r0), 64'd64);
        chk({tag, "_ss_falls"}, 64'(ss_falls - f0), 64'd1);
        chk({tag, "_ss_rises"}, 64'(ss_rises - u0), 64'd1);
        chk({tag, "_mosi"}, slv_rx, {pl, op});
        chk({tag, "_rsp"}, rsp_data, resp);
    endtask

    // Autonomous INIT frame after reset release, when that build option is enabled
    task automatic init_seq();
`ifdef SPI_CMD_MASTER_AUTO_INIT_EN
        int n, r0, p0;
        bit bad;
        r0 = sck_rises;
        p0 = rsp_pulses;
        bad = 1'b0;
        n = 0;
        @(negedge CLK);
        while (SPI_SS !== 1'b0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("init_ss_fall", 64'(n < 50), 64'd1);
        n = 0;
        while (SPI_SS !== 1'b1 && n < 3000) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge CLK);
            n++;
        end
        chk("init_ss_rise", 64'(n < 3000), 64'd1);
        chk("init_rdy_busy", 64'(bad), 64'd0);
        chk("init_sck_rises", 64'(sck_rises - r0), 64'd8);
        chk("init_byte", slv_rx, 64'h11);
        @(negedge CLK);
        #1;
        chk("init_no_rsp", 64'(rsp_pulses - p0), 64'd0);
        chk("init_rdy_after", 64'(cmd_ready), 64'd1);
`endif
    endtask

    initial begin
        logic [7:0]  rb [8] = '{8'h40, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C};
        logic [7:0]  ops [6] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h06, 8'h07};
        logic [63:0] resp, resp_b;
        int a1, d1, a2, d2, p0, h0, n;

        // Reset values
        #1 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ss", 64'(SPI_SS), 64'd1);
        chk("rst_sck", 64'(SPI_SCK), 64'd0);
        chk("rst_mosi", 64'(SPI_MOSI), 64'd0);
        chk("rst_rdy", 64'(cmd_ready), 64'(RDY_RST));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vld", 64'(rsp_valid), 64'd0);
        chk("rst_data", rsp_data, 64'd0);
        RST_N = 1'b1;
        init_seq();
        repeat (20) @(negedge CLK);
        #1;
        chk("idle_rdy", 64'(cmd_ready), 64'd1);
        chk("idle_no_rsp", 64'(rsp_pulses), 64'd0);

        // WR_LEDS frame with a fixed reply pattern
        resp = '0;
        for (int k = 0; k < 8; k++) resp[8*k +: 8] = rb[k];
        @(negedge CLK);
        run_frame("leds", 8'h04, 56'h05, resp, 1'b0, a1, d1);

        // Back-to-back with cmd_valid held high
        #1;
        p0 = rsp_pulses;
        h0 = rsp_hi;
        resp_b = rnd64();
        run_frame("b2b_a", 8'h06, 56'(rnd64()), rnd64(), 1'b1, a1, d1);
        run_frame("b2b_b", 8'h07, 56'(rnd64()), resp_b, 1'b0, a2, d2);
        chk("b2b_accept_gap", 64'(a2 - d1), 64'd1);
        @(negedge CLK);
        #1;
        chk("b2b_pulses", 64'(rsp_pulses - p0), 64'd2);
        chk("b2b_pulse_width", 64'(rsp_hi - h0), 64'd2);
        chk("b2b_rsp_held", rsp_data, resp_b);
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        chk("b2b_idle_rdy", 64'(cmd_ready), 64'd1);

        // Reset asserted during byte 3
        @(negedge CLK);
        slv_tx      = rnd64();
        cmd_opcode  = 8'h04;
        cmd_payload = 56'(rnd64());
        cmd_valid   = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        n = 0;
        while (slv_bits < 28 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_reach_byte3", 64'(n < 2000), 64'd1);
        p0 = rsp_pulses;
        #2 RST_N = 1'b0;
        #1;
        chk("mid_ss", 64'(SPI_SS), 64'd1);
        chk("mid_sck", 64'(SPI_SCK), 64'd0);
        chk("mid_mosi", 64'(SPI_MOSI), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rdy", 64'(cmd_ready), 64'(RDY_RST));
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        init_seq();
        @(negedge CLK);
        #1;
        chk("mid_no_rsp", 64'(rsp_pulses - p0), 64'd0);
        @(negedge CLK);
        run_frame("post_rst", 8'h06, 56'(rnd64()), rnd64(), 1'b0, a1, d1);

        // Random frames
        for (int i = 0; i < 3; i++) begin
            run_frame("rnd", ops[$urandom_range(0, 5)], 56'(rnd64()), rnd64(), 1'b0, a1, d1);
        end
        repeat (3) @(negedge CLK);
        #1;
        chk("total_pulses", 64'(rsp_pulses), 64'd7);
        chk("total_width", 64'(rsp_hi), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
